mem_ctrl: RTL and testbench

Memory controller between the core and the single-port byte-wide RAM. It serves instruction-cache line refills from ifetch: a 64-byte line is returned on a 512-bit bus with a one-cycle done pulse. It also serves 1/2/4-byte data loads and stores from the load/store buffer. It owns the RAM address, data and write-enable pins and serialises all traffic one byte per cycle.

---
 rtl/mem_ctrl_pkg.sv | 12 +
 rtl/mem_ctrl.sv | 118 +++++++++++
 tb/tb_mem_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: FSM states, line geometry, access-size codes and IO-region predicate for mem_ctrl
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, IF_READ, LS_READ, LS_WRITE} state_t;
  localparam int LINE_BYTES = 64;
  localparam int LINE_LOG2 = $clog2(LINE_BYTES);
  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;
  function automatic logic is_io(input logic [31:0] addr);
    return (addr & 32'h0003_0000) == 32'h0003_0000;
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller (mem_*) serving icache line refills (if_*) and 1/2/4-byte LSB loads/stores (lsb_*)
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  input  logic [31:0]             if_addr,
  input  logic                    if_req,
  output logic [8*LINE_BYTES-1:0] if_row,
  output logic                    if_done,
  input  logic                    lsb_req,
  input  logic                    lsb_wr,
  input  logic [31:0]             lsb_addr,
  input  logic [1:0]              lsb_len,
  input  logic [31:0]             lsb_wdata,
  output logic [31:0]             lsb_rdata,
  output logic                    lsb_done
);
  state_t state, state_n;
  logic [LINE_LOG2-1:0] cnt, cnt_n, nb;
  logic [31:0] mem_a_n, lsb_rdata_n;
  logic [7:0] mem_dout_n;
  logic [8*LINE_BYTES-1:0] if_row_n;
  logic mem_wr_n, if_done_n, lsb_done_n, wr_ok;
  assign nb = lsb_len == LEN_B ? LINE_LOG2'(1) : lsb_len == LEN_H ? LINE_LOG2'(2) : lsb_len == LEN_W ? LINE_LOG2'(4) : LINE_LOG2'(1);
  assign wr_ok = !(is_io(lsb_addr) && io_buffer_full);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    mem_a_n = mem_a;
    mem_dout_n = mem_dout;
    mem_wr_n = 1'b0;
    if_row_n = if_row;
    if_done_n = 1'b0;
    lsb_rdata_n = lsb_rdata;
    lsb_done_n = 1'b0;
    case (state)
      IDLE: if (!if_done && !lsb_done) begin
        if (lsb_req && lsb_wr) begin
          state_n = LS_WRITE;
          cnt_n = wr_ok ? LINE_LOG2'(1) : '0;
          mem_a_n = wr_ok ? lsb_addr : mem_a;
          mem_dout_n = wr_ok ? lsb_wdata[7:0] : mem_dout;
          mem_wr_n = wr_ok;
        end else if (lsb_req) begin
          state_n = LS_READ;
          cnt_n = '0;
          mem_a_n = lsb_addr;
          lsb_rdata_n = '0;
        end else if (if_req) begin
          state_n = IF_READ;
          cnt_n = '0;
          mem_a_n = if_addr & ~32'(LINE_BYTES - 1);
        end
      end
      IF_READ: begin
        if_row_n = {mem_din, if_row[8*LINE_BYTES-1:8]};
        if (cnt == LINE_LOG2'(LINE_BYTES - 1)) begin
          state_n = IDLE;
          if_done_n = 1'b1;
        end else begin
          mem_a_n = mem_a + 32'd1;
          cnt_n = cnt + 1'b1;
        end
      end
      LS_READ: begin
        lsb_rdata_n[8*cnt[1:0] +: 8] = mem_din;
        if (cnt == nb - 1'b1) begin
          state_n = IDLE;
          lsb_done_n = 1'b1;
        end else begin
          mem_a_n = mem_a + 32'd1;
          cnt_n = cnt + 1'b1;
        end
      end
      LS_WRITE: begin
        if (cnt == nb) begin
          state_n = IDLE;
          lsb_done_n = 1'b1;
        end else if (wr_ok) begin
          mem_a_n = lsb_addr + 32'(cnt);
          mem_dout_n = lsb_wdata[8*cnt[1:0] +: 8];
          mem_wr_n = 1'b1;
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      mem_a <= '0;
      mem_dout <= '0;
      mem_wr <= 1'b0;
      if_row <= '0;
      if_done <= 1'b0;
      lsb_rdata <= '0;
      lsb_done <= 1'b0;
    end else if (rdy) begin
      state <= state_n;
      cnt <= cnt_n;
      mem_a <= mem_a_n;
      mem_dout <= mem_dout_n;
      mem_wr <= mem_wr_n;
      if_row <= if_row_n;
      if_done <= if_done_n;
      lsb_rdata <= lsb_rdata_n;
      lsb_done <= lsb_done_n;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized self-checking bench for mem_ctrl against a transaction-level RAM model
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst, rdy, io_buffer_full, if_req, lsb_req, lsb_wr, mem_wr, if_done, lsb_done;
  logic [7:0] mem_din, mem_dout;
  logic [31:0] mem_a, if_addr, lsb_addr, lsb_wdata, lsb_rdata;
  logic [1:0] lsb_len;
  logic [511:0] if_row;
  logic [7:0] ram [0:65535];
  bit written [0:65535];
  logic [7:0] ref_ram [0:65535];
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .if_addr(if_addr), .if_req(if_req),
    .if_row(if_row), .if_done(if_done), .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr),
    .lsb_len(lsb_len), .lsb_wdata(lsb_wdata), .lsb_rdata(lsb_rdata), .lsb_done(lsb_done)
  );
  assign mem_din = written[mem_a[15:0]] ? ram[mem_a[15:0]] : mem_a[7:0];
  always @(posedge clk)
    if (mem_wr) begin
      ram[mem_a[15:0]] <= mem_dout;
      written[mem_a[15:0]] <= 1'b1;
    end
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_fill(input logic [31:0] addr, input int rdy_at, output logic [511:0] row);
    logic [31:0] base, frozen;
    logic [511:0] exp;
    int c, raw, h;
    bit r, seen;
    base = addr & 32'hFFFF_FFC0;
    c = 0; raw = 0; h = 0; seen = 0; frozen = '0; row = '0;
    for (int k = 0; k < 64; k++) exp[8*k +: 8] = ref_ram[16'(base + 32'(k))];
    if_addr = addr;
    if_req = 1'b1;
    while (!seen && raw < 300) begin
      r = rdy;
      tick();
      raw++;
      if (r) c++;
      if (!r) check("fill_frozen", mem_a, frozen);
      else if (c <= 64) check("fill_addr", mem_a, base + 32'(c - 1));
      if (if_done) begin
        seen = 1;
        row = if_row;
        check("fill_lat", c, 65);
        check("fill_raw", raw, rdy_at != 0 ? 69 : 65);
        check("fill_row", if_row, exp);
      end
      if (rdy_at != 0 && c == rdy_at && r) begin
        rdy = 1'b0;
        frozen = mem_a;
        h = 4;
      end else if (!r) begin
        h--;
        if (h == 0) rdy = 1'b1;
      end
    end
    check("fill_done_seen", seen, 1);
    if_req = 1'b0;
    rdy = 1'b1;
    tick();
    check("fill_pulse", if_done, 0);
  endtask
  task automatic do_load(input logic [31:0] addr, input logic [1:0] len, output logic [31:0] rd);
    int n, c;
    bit seen;
    logic [31:0] exp;
    n = 1 << len; c = 0; seen = 0; exp = '0; rd = '0;
    for (int k = 0; k < n; k++) exp[8*k +: 8] = ref_ram[16'(addr + 32'(k))];
    lsb_addr = addr; lsb_len = len; lsb_wr = 1'b0; lsb_req = 1'b1;
    while (!seen && c < 50) begin
      tick();
      c++;
      check("ld_no_wr", mem_wr, 0);
      if (lsb_done) begin
        seen = 1;
        rd = lsb_rdata;
        check("ld_lat", c, n + 1);
        check("ld_data", lsb_rdata, exp);
      end
    end
    check("ld_done_seen", seen, 1);
    lsb_req = 1'b0;
    tick();
    check("ld_pulse", lsb_done, 0);
  endtask
  task automatic do_store(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] data, input int stall);
    int n, s, c;
    bit seen;
    logic [31:0] wa [$];
    logic [7:0] wd [$];
    n = 1 << len; c = 0; seen = 0;
    s = addr[17:16] == 2'b11 ? stall : 0;
    lsb_addr = addr; lsb_len = len; lsb_wdata = data; lsb_wr = 1'b1;
    io_buffer_full = stall > 0;
    lsb_req = 1'b1;
    while (!seen && c < 50) begin
      tick();
      c++;
      if (c == stall) io_buffer_full = 1'b0;
      if (mem_wr) begin
        wa.push_back(mem_a);
        wd.push_back(mem_dout);
      end
      if (lsb_done) begin
        seen = 1;
        check("st_lat", c, n + 1 + s);
        check("st_wr_end", mem_wr, 0);
      end
    end
    check("st_done_seen", seen, 1);
    lsb_req = 1'b0;
    io_buffer_full = 1'b0;
    check("st_count", wa.size(), n);
    for (int k = 0; k < n && k < wa.size(); k++) begin
      check("st_addr", wa[k], addr + 32'(k));
      check("st_data", wd[k], data[8*k +: 8]);
    end
    for (int k = 0; k < n; k++) ref_ram[16'(addr + 32'(k))] = data[8*k +: 8];
    tick();
    check("st_pulse", lsb_done, 0);
  endtask
  initial begin
    logic [31:0] rd, a;
    logic [511:0] row1, row2;
    logic [1:0] len;
    int c, ld, fd, op;
    bit seen;
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; if_req = 1'b0; lsb_req = 1'b0; lsb_wr = 1'b0;
    if_addr = '0; lsb_addr = '0; lsb_len = '0; lsb_wdata = '0;
    for (int i = 0; i < 65536; i++) ref_ram[i] = 8'(i);
    tick();
    tick();
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_dout", mem_dout, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_if_row", if_row, 0);
    check("rst_if_done", if_done, 0);
    check("rst_lsb_rdata", lsb_rdata, 0);
    check("rst_lsb_done", lsb_done, 0);
    rst = 1'b0;
    tick();
    do_fill(32'h0000_1234, 0, row1);
    check("fill_first_byte", row1[7:0], 8'h00);
    check("fill_last_byte", row1[511:504], 8'h3F);
    do_store(32'h1000, 2'd2, 32'h4433_2211, 0);
    do_load(32'h1000, 2'd2, rd);
    check("word_ld", rd, 32'h4433_2211);
    do_load(32'h1003, 2'd0, rd);
    check("byte_ld", rd, 32'h0000_0044);
    do_store(32'h2002, 2'd1, 32'hDEAD_BEEF, 0);
    check("half_st_lo", ram[16'h2002], 8'hEF);
    check("half_st_hi", ram[16'h2003], 8'hBE);
    lsb_addr = 32'h1000; lsb_len = 2'd2; lsb_wr = 1'b0; if_addr = 32'h5040;
    lsb_req = 1'b1; if_req = 1'b1;
    c = 0; ld = 0; fd = 0;
    while (fd == 0 && c < 300) begin
      tick();
      c++;
      if (lsb_done) begin
        ld = c;
        lsb_req = 1'b0;
        check("arb_ld_data", lsb_rdata, 32'h4433_2211);
      end
      if (c == 7) check("arb_fill_base", mem_a, 32'h5040);
      if (if_done) begin
        fd = c;
        if_req = 1'b0;
      end
    end
    check("arb_ld_lat", ld, 5);
    check("arb_fill_lat", fd, 71);
    repeat (3) begin
      tick();
      check("arb_no_accept", {mem_a, if_done, lsb_done}, {32'h507F, 2'b00});
    end
    do_store(32'h0003_0000, 2'd0, 32'h0000_00A5, 3);
    do_fill(32'h0000_1234, 20, row2);
    check("rdy_row", row2, row1);
    if_addr = 32'h1234;
    if_req = 1'b1;
    repeat (30) tick();
    rst = 1'b1;
    tick();
    check("abort_mem_a", mem_a, 0);
    check("abort_if_row", if_row, 0);
    check("abort_outs", {mem_wr, if_done, lsb_done, mem_dout, lsb_rdata}, 0);
    rst = 1'b0;
    if_req = 1'b0;
    seen = 0;
    repeat (80) begin
      tick();
      if (if_done) seen = 1;
    end
    check("abort_no_done", seen, 0);
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 65535));
      op = int'($urandom_range(0, 2));
      len = 2'($urandom_range(0, 2));
      if (op == 0) do_fill(a, $urandom_range(0, 1) != 0 ? 0 : int'($urandom_range(1, 60)), row1);
      else if (op == 1) do_load(a, len, rd);
      else do_store($urandom_range(0, 3) == 0 ? a | 32'h0003_0000 : a, len, $urandom, int'($urandom_range(0, 3)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
